// File: rtl/frame_row_scheduler_if.sv
// -----------------------------------------------------------------------------
// frame_row_scheduler_if
// Control/status bundle between the frame controller (master) and the
// frame_row_scheduler (slave).
//   master drives : ENABLE, ABORT, CLR_STATUS, EXT_ROW_MODE, ROWS, ROW_LEN,
//                   REC_DELAY, FSYNC_STROBE, R2S_STROBE
//   slave drives  : GEN_START, REC_START, ROW_IDX, FRAME_CNT, BUSY, DONE,
//                   OVERRUN, MISSED_R2S
// -----------------------------------------------------------------------------
interface frame_row_scheduler_if #(
   parameter int ROW_W   = 8,
   parameter int LEN_W   = 16,
   parameter int FRAME_W = 16,
   parameter int MISS_W  = 8
);
   logic               ENABLE;
   logic               ABORT;
   logic               CLR_STATUS;
   logic               EXT_ROW_MODE;
   logic [ROW_W-1:0]   ROWS;
   logic [LEN_W-1:0]   ROW_LEN;
   logic [LEN_W-1:0]   REC_DELAY;
   logic               FSYNC_STROBE;
   logic               R2S_STROBE;

   logic               GEN_START;
   logic               REC_START;
   logic [ROW_W-1:0]   ROW_IDX;
   logic [FRAME_W-1:0] FRAME_CNT;
   logic               BUSY;
   logic               DONE;
   logic               OVERRUN;
   logic [MISS_W-1:0]  MISSED_R2S;

   modport master (
      output ENABLE, ABORT, CLR_STATUS, EXT_ROW_MODE, ROWS, ROW_LEN, REC_DELAY,
             FSYNC_STROBE, R2S_STROBE,
      input  GEN_START, REC_START, ROW_IDX, FRAME_CNT, BUSY, DONE, OVERRUN,
             MISSED_R2S
   );

   modport slave (
      input  ENABLE, ABORT, CLR_STATUS, EXT_ROW_MODE, ROWS, ROW_LEN, REC_DELAY,
             FSYNC_STROBE, R2S_STROBE,
      output GEN_START, REC_START, ROW_IDX, FRAME_CNT, BUSY, DONE, OVERRUN,
             MISSED_R2S
   );
endinterface

// File: rtl/frame_row_scheduler.sv
// -----------------------------------------------------------------------------
// frame_row_scheduler
// Sequences one detector frame of row readouts in the CLK_80 domain: issues
// GEN_START (seq_gen) and REC_START (seq_rec) per row, with rows triggered by
// R2S_STROBE or back-to-back from an internal row timer. Counts ignored row
// strobes and frame-sync overruns for diagnostics.
// Ports:
//   CLK   - CLK_80 domain clock
//   RST_N - asynchronous active-low reset
//   bus   - frame_row_scheduler_if.slave (config, strobes, starts, status)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | disabled, waits for ENABLE
// ARMED    | waits for FSYNC_STROBE to latch config and start a frame
// ROW_WAIT | between rows, waits for the row trigger
// ROW_RUN  | row in progress, run_cnt counts 0 .. max(ROW_LEN,1)-1
// -----------------------------------------------------------------------------
module frame_row_scheduler #(
   parameter int ROW_W   = 8,
   parameter int LEN_W   = 16,
   parameter int FRAME_W = 16,
   parameter int MISS_W  = 8
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   frame_row_scheduler_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ARMED    = 2'd1,
      S_ROW_WAIT = 2'd2,
      S_ROW_RUN  = 2'd3
   } state_t;

   localparam logic [ROW_W-1:0]   ROW_ONE   = ROW_W'(1);
   localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
   localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);
   localparam logic [MISS_W-1:0]  MISS_ONE  = MISS_W'(1);

   state_t             state;
   logic [ROW_W-1:0]   rows_m1_sh;
   logic [LEN_W-1:0]   len_m1_sh;
   logic [LEN_W-1:0]   rec_idx_sh;
   logic               ext_sh;
   logic [LEN_W-1:0]   run_cnt;

   logic               gen_start;
   logic               rec_start;
   logic [ROW_W-1:0]   row_idx;
   logic [FRAME_W-1:0] frame_cnt;
   logic               busy;
   logic               done;
   logic               overrun;
   logic [MISS_W-1:0]  missed;

   logic [ROW_W-1:0]   rows_m1_in;
   logic [LEN_W-1:0]   len_m1_in;
   logic [LEN_W-1:0]   rec_idx_in;
   logic               row_trig;
   logic               miss_evt;
   logic               ovr_evt;

   always_comb begin
      rows_m1_in = '0;
      len_m1_in  = '0;
      rec_idx_in = '0;
      if (bus.ROWS != '0)
         rows_m1_in = bus.ROWS - ROW_ONE;
      if (bus.ROW_LEN != '0)
         len_m1_in = bus.ROW_LEN - LEN_ONE;
      // REC_START is clamped to the last run cycle so every row gets exactly one
      rec_idx_in = (bus.REC_DELAY > len_m1_in) ? len_m1_in : bus.REC_DELAY;
   end

   // Internal mode: ROW_WAIT is always a one-cycle trigger state.
   assign row_trig = (state == S_ROW_WAIT) && (ext_sh ? bus.R2S_STROBE : 1'b1);
   assign miss_evt = bus.R2S_STROBE &&
                     ((state == S_ROW_RUN) || ((state == S_ROW_WAIT) && !ext_sh));
   // The DONE cycle still belongs to the finishing frame.
   assign ovr_evt  = bus.FSYNC_STROBE && (busy || done);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= S_IDLE;
         rows_m1_sh <= '0;
         len_m1_sh  <= '0;
         rec_idx_sh <= '0;
         ext_sh     <= 1'b0;
         run_cnt    <= '0;
         gen_start  <= 1'b0;
         rec_start  <= 1'b0;
         row_idx    <= '0;
         frame_cnt  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
         missed     <= '0;
      end else begin
         gen_start <= 1'b0;
         rec_start <= 1'b0;
         done      <= 1'b0;

         if (bus.CLR_STATUS) begin
            overrun <= 1'b0;
            missed  <= '0;
         end

         if (bus.ABORT) begin
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            if (ovr_evt)
               overrun <= 1'b1;
            if (miss_evt) begin
               if (bus.CLR_STATUS)
                  missed <= MISS_ONE;
               else if (missed != '1)
                  missed <= missed + MISS_ONE;
            end

            case (state)
               S_IDLE: begin
                  if (bus.ENABLE)
                     state <= S_ARMED;
               end
               S_ARMED: begin
                  if (!bus.ENABLE) begin
                     state <= S_IDLE;
                  end else if (bus.FSYNC_STROBE && !done) begin
                     rows_m1_sh <= rows_m1_in;
                     len_m1_sh  <= len_m1_in;
                     rec_idx_sh <= rec_idx_in;
                     ext_sh     <= bus.EXT_ROW_MODE;
                     row_idx    <= '0;
                     busy       <= 1'b1;
                     state      <= S_ROW_WAIT;
                  end
               end
               S_ROW_WAIT: begin
                  if (row_trig) begin
                     state     <= S_ROW_RUN;
                     gen_start <= 1'b1;
                     rec_start <= (rec_idx_sh == '0);
                     run_cnt   <= '0;
                  end
               end
               S_ROW_RUN: begin
                  if (run_cnt == len_m1_sh) begin
                     if (row_idx == rows_m1_sh) begin
                        done      <= 1'b1;
                        frame_cnt <= frame_cnt + FRAME_ONE;
                        busy      <= 1'b0;
                        state     <= bus.ENABLE ? S_ARMED : S_IDLE;
                     end else begin
                        row_idx <= row_idx + ROW_ONE;
                        state   <= S_ROW_WAIT;
                     end
                  end else begin
                     run_cnt   <= run_cnt + LEN_ONE;
                     rec_start <= ((run_cnt + LEN_ONE) == rec_idx_sh);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.GEN_START  = gen_start;
   assign bus.REC_START  = rec_start;
   assign bus.ROW_IDX    = row_idx;
   assign bus.FRAME_CNT  = frame_cnt;
   assign bus.BUSY       = busy;
   assign bus.DONE       = done;
   assign bus.OVERRUN    = overrun;
   assign bus.MISSED_R2S = missed;

endmodule

// File: tb/tb_frame_row_scheduler.sv
module tb_frame_row_scheduler;
   localparam int ROW_W   = 8;
   localparam int LEN_W   = 16;
   localparam int FRAME_W = 16;
   localparam int MISS_W  = 8;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   frame_row_scheduler_if #(.ROW_W(ROW_W), .LEN_W(LEN_W), .FRAME_W(FRAME_W), .MISS_W(MISS_W)) bus ();

   frame_row_scheduler #(.ROW_W(ROW_W), .LEN_W(LEN_W), .FRAME_W(FRAME_W), .MISS_W(MISS_W)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int exp_frames = 0;

   int gen_q[$], rec_q[$], done_q[$];
   int exp_gen[$], exp_rec[$], exp_done[$];
   int fs_plan[$], r2s_plan[$], clr_plan[$], abort_plan[$];

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (bus.GEN_START) gen_q.push_back(cyc);
      if (bus.REC_START) rec_q.push_back(cyc);
      if (bus.DONE)      done_q.push_back(cyc);
   end

   function automatic bit in_q(input int q[$], input int v);
      foreach (q[i]) if (q[i] == v) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit q_eq(input int a[$], input int b[$]);
      if (a.size() != b.size()) return 1'b0;
      foreach (a[i]) if (a[i] != b[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int first_or_neg(input int q[$]);
      return (q.size() > 0) ? q[0] : -1;
   endfunction

   function automatic void clear_all();
      gen_q.delete(); rec_q.delete(); done_q.delete();
      exp_gen.delete(); exp_rec.delete(); exp_done.delete();
      fs_plan.delete(); r2s_plan.delete(); clr_plan.delete(); abort_plan.delete();
   endfunction

   // Internal mode: FSYNC at t, row k starts at t+2+k*(L+1), frame ends t+1+R*(L+1).
   function automatic void model_internal(input int t, input int rows, input int len, input int dly);
      int r, l, off;
      r   = (rows == 0) ? 1 : rows;
      l   = (len == 0) ? 1 : len;
      off = (dly < l - 1) ? dly : l - 1;
      for (int k = 0; k < r; k++) begin
         exp_gen.push_back(t + 2 + k * (l + 1));
         exp_rec.push_back(t + 2 + k * (l + 1) + off);
      end
      exp_done.push_back(t + 1 + r * (l + 1));
   endfunction

   // External mode: each accepted row strobe at s starts a row at s+1.
   function automatic void model_external(input int strobes[$], input int len, input int dly);
      int l, off, g;
      l   = (len == 0) ? 1 : len;
      off = (dly < l - 1) ? dly : l - 1;
      g   = 0;
      foreach (strobes[i]) begin
         g = strobes[i] + 1;
         exp_gen.push_back(g);
         exp_rec.push_back(g + off);
      end
      exp_done.push_back(g + l);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic run_plan(input int n);
      for (int i = 0; i < n; i++) begin
         bus.FSYNC_STROBE = in_q(fs_plan, cyc);
         bus.R2S_STROBE   = in_q(r2s_plan, cyc);
         bus.CLR_STATUS   = in_q(clr_plan, cyc);
         bus.ABORT        = in_q(abort_plan, cyc);
         tick(1);
      end
      bus.FSYNC_STROBE = 1'b0;
      bus.R2S_STROBE   = 1'b0;
      bus.CLR_STATUS   = 1'b0;
      bus.ABORT        = 1'b0;
   endtask

   task automatic set_cfg(input bit ext, input int rows, input int len, input int dly);
      bus.EXT_ROW_MODE = ext;
      bus.ROWS         = ROW_W'(rows);
      bus.ROW_LEN      = LEN_W'(len);
      bus.REC_DELAY    = LEN_W'(dly);
   endtask

   task automatic test_reset();
      bus.ENABLE = 1'b0; bus.ABORT = 1'b0; bus.CLR_STATUS = 1'b0;
      bus.FSYNC_STROBE = 1'b0; bus.R2S_STROBE = 1'b0;
      set_cfg(1'b0, 0, 0, 0);
      RST_N = 1'b0;
      tick(3);
      vectors++;
      if ({bus.GEN_START, bus.REC_START, bus.ROW_IDX, bus.FRAME_CNT, bus.BUSY, bus.DONE,
           bus.OVERRUN, bus.MISSED_R2S} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: gen=%0b rec=%0b row=%0d frame=%0d busy=%0b done=%0b ovr=%0b miss=%0d, want all 0",
                  bus.GEN_START, bus.REC_START, bus.ROW_IDX, bus.FRAME_CNT, bus.BUSY, bus.DONE,
                  bus.OVERRUN, bus.MISSED_R2S);
      end
      RST_N = 1'b1;
      bus.ENABLE = 1'b1;
      tick(3);
      vectors++;
      if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
         errors++;
         $display("FAIL armed_idle_outputs: busy=%0b done=%0b, want 0 0", bus.BUSY, bus.DONE);
      end
   endtask

   task automatic test_internal();
      for (int i = 0; i < 7; i++) begin
         int rows, len, dly, t, reff;
         if (i == 0) begin
            rows = 3; len = 4; dly = 2;
         end else begin
            rows = int'($urandom_range(4, 0));
            len  = int'($urandom_range(6, 0));
            dly  = int'($urandom_range(8, 0));
         end
         set_cfg(1'b0, rows, len, dly);
         clear_all();
         t = cyc + 2;
         fs_plan.push_back(t);
         model_internal(t, rows, len, dly);
         run_plan(exp_done[0] + 4 - cyc);
         exp_frames++;
         reff = (rows == 0) ? 1 : rows;
         vectors++;
         if (!q_eq(gen_q, exp_gen)) begin
            errors++;
            $display("FAIL int_gen[%0d]: got %0d pulses first@%0d, want %0d first@%0d", i,
                     gen_q.size(), first_or_neg(gen_q) - t, exp_gen.size(), first_or_neg(exp_gen) - t);
         end
         vectors++;
         if (!q_eq(rec_q, exp_rec)) begin
            errors++;
            $display("FAIL int_rec[%0d]: got %0d pulses first@%0d, want %0d first@%0d", i,
                     rec_q.size(), first_or_neg(rec_q) - t, exp_rec.size(), first_or_neg(exp_rec) - t);
         end
         vectors++;
         if (!q_eq(done_q, exp_done)) begin
            errors++;
            $display("FAIL int_done[%0d]: got %0d pulses first@%0d, want %0d first@%0d", i,
                     done_q.size(), first_or_neg(done_q) - t, exp_done.size(), first_or_neg(exp_done) - t);
         end
         vectors++;
         if (bus.FRAME_CNT !== FRAME_W'(exp_frames) || bus.ROW_IDX !== ROW_W'(reff - 1) || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL int_status[%0d]: frame=%0d row=%0d busy=%0b, want %0d %0d 0", i,
                     bus.FRAME_CNT, bus.ROW_IDX, bus.BUSY, exp_frames, reff - 1);
         end
      end
   endtask

   task automatic test_external();
      for (int i = 0; i < 7; i++) begin
         int rows, len, dly, t, reff, leff, s, exp_miss;
         int strobes[$];
         if (i == 0) begin
            rows = 2; len = 3; dly = 5;
         end else begin
            rows = int'($urandom_range(4, 0));
            len  = int'($urandom_range(6, 0));
            dly  = int'($urandom_range(8, 0));
         end
         reff = (rows == 0) ? 1 : rows;
         leff = (len == 0) ? 1 : len;
         set_cfg(1'b1, rows, len, dly);
         clear_all();
         t = cyc + 2;
         fs_plan.push_back(t);
         // A strobe while ARMED is neither a trigger nor a miss.
         r2s_plan.push_back(t - 1);
         clr_plan.push_back(t - 1);
         exp_miss = 0;
         if (i == 0) begin
            strobes.push_back(t + 10);
            strobes.push_back(t + 20);
         end else begin
            s = t + 1 + int'($urandom_range(4, 0));
            for (int k = 0; k < reff; k++) begin
               strobes.push_back(s);
               if ($urandom_range(1, 0) == 1) begin
                  r2s_plan.push_back(s + 1 + int'($urandom_range(leff - 1, 0)));
                  exp_miss++;
               end
               s = s + 1 + leff + int'($urandom_range(4, 0));
            end
         end
         foreach (strobes[k]) r2s_plan.push_back(strobes[k]);
         model_external(strobes, len, dly);
         run_plan(exp_done[0] + 4 - cyc);
         exp_frames++;
         vectors++;
         if (!q_eq(gen_q, exp_gen)) begin
            errors++;
            $display("FAIL ext_gen[%0d]: got %0d pulses first@%0d, want %0d first@%0d", i,
                     gen_q.size(), first_or_neg(gen_q) - t, exp_gen.size(), first_or_neg(exp_gen) - t);
         end
         vectors++;
         if (!q_eq(rec_q, exp_rec)) begin
            errors++;
            $display("FAIL ext_rec[%0d]: got %0d pulses first@%0d, want %0d first@%0d", i,
                     rec_q.size(), first_or_neg(rec_q) - t, exp_rec.size(), first_or_neg(exp_rec) - t);
         end
         vectors++;
         if (!q_eq(done_q, exp_done)) begin
            errors++;
            $display("FAIL ext_done[%0d]: got %0d pulses first@%0d, want %0d first@%0d", i,
                     done_q.size(), first_or_neg(done_q) - t, exp_done.size(), first_or_neg(exp_done) - t);
         end
         vectors++;
         if (bus.FRAME_CNT !== FRAME_W'(exp_frames) || bus.ROW_IDX !== ROW_W'(reff - 1) ||
             bus.MISSED_R2S !== MISS_W'(exp_miss)) begin
            errors++;
            $display("FAIL ext_status[%0d]: frame=%0d row=%0d miss=%0d, want %0d %0d %0d", i,
                     bus.FRAME_CNT, bus.ROW_IDX, bus.MISSED_R2S, exp_frames, reff - 1, exp_miss);
         end
      end
   endtask

   task automatic test_missed();
      int t;
      set_cfg(1'b1, 1, 400, 0);
      clear_all();
      t = cyc + 2;
      clr_plan.push_back(t - 2);
      fs_plan.push_back(t);
      r2s_plan.push_back(t - 1);
      r2s_plan.push_back(t + 3);
      r2s_plan.push_back(t + 10);
      r2s_plan.push_back(t + 11);
      r2s_plan.push_back(t + 50);
      run_plan(t + 410 - cyc);
      exp_frames++;
      vectors++;
      if (bus.MISSED_R2S !== MISS_W'(3) || done_q.size() != 1) begin
         errors++;
         $display("FAIL miss_count3: miss=%0d dones=%0d, want 3 1", bus.MISSED_R2S, done_q.size());
      end
      clear_all();
      t = cyc + 2;
      fs_plan.push_back(t);
      r2s_plan.push_back(t + 1);
      for (int k = 0; k < 300; k++) r2s_plan.push_back(t + 5 + k);
      run_plan(t + 410 - cyc);
      exp_frames++;
      vectors++;
      if (bus.MISSED_R2S !== '1) begin
         errors++;
         $display("FAIL miss_saturate: miss=%0d, want 255", bus.MISSED_R2S);
      end
      clear_all();
      clr_plan.push_back(cyc);
      run_plan(2);
      vectors++;
      if (bus.MISSED_R2S !== '0) begin
         errors++;
         $display("FAIL miss_clear: miss=%0d, want 0", bus.MISSED_R2S);
      end
      set_cfg(1'b1, 1, 5, 0);
      clear_all();
      t = cyc + 2;
      fs_plan.push_back(t);
      r2s_plan.push_back(t + 1);
      r2s_plan.push_back(t + 3);
      clr_plan.push_back(t + 3);
      run_plan(t + 15 - cyc);
      exp_frames++;
      vectors++;
      if (bus.MISSED_R2S !== MISS_W'(1)) begin
         errors++;
         $display("FAIL miss_clr_collide: miss=%0d, want 1", bus.MISSED_R2S);
      end
   endtask

   task automatic test_overrun();
      int t;
      set_cfg(1'b0, 3, 4, 1);
      clear_all();
      t = cyc + 2;
      clr_plan.push_back(t - 1);
      fs_plan.push_back(t);
      fs_plan.push_back(t + 8);
      run_plan(t + 19 - cyc);
      vectors++;
      if (bus.OVERRUN !== 1'b1) begin
         errors++;
         $display("FAIL ovr_set: overrun=%0b, want 1", bus.OVERRUN);
      end
      model_internal(t, 3, 4, 1);
      vectors++;
      if (!q_eq(gen_q, exp_gen) || !q_eq(done_q, exp_done)) begin
         errors++;
         $display("FAIL ovr_frame_intact: gens=%0d dones=%0d, want %0d %0d",
                  gen_q.size(), done_q.size(), exp_gen.size(), exp_done.size());
      end
      fs_plan.push_back(t + 20);
      clr_plan.push_back(t + 25);
      run_plan(t + 31 - cyc);
      vectors++;
      if (bus.OVERRUN !== 1'b0 || bus.BUSY !== 1'b1) begin
         errors++;
         $display("FAIL ovr_cleared: overrun=%0b busy=%0b, want 0 1", bus.OVERRUN, bus.BUSY);
      end
      // FSYNC coincident with DONE: rejected, flagged as overrun.
      fs_plan.push_back(t + 36);
      model_internal(t + 20, 3, 4, 1);
      run_plan(t + 50 - cyc);
      exp_frames += 2;
      vectors++;
      if (!q_eq(gen_q, exp_gen) || !q_eq(done_q, exp_done) || bus.OVERRUN !== 1'b1) begin
         errors++;
         $display("FAIL ovr_done_fsync: gens=%0d dones=%0d overrun=%0b, want %0d %0d 1",
                  gen_q.size(), done_q.size(), bus.OVERRUN, exp_gen.size(), exp_done.size());
      end
      vectors++;
      if (bus.FRAME_CNT !== FRAME_W'(exp_frames)) begin
         errors++;
         $display("FAIL ovr_frame_cnt: frame=%0d, want %0d", bus.FRAME_CNT, exp_frames);
      end
   endtask

   task automatic test_abort();
      int t;
      set_cfg(1'b0, 3, 4, 2);
      clear_all();
      t = cyc + 2;
      fs_plan.push_back(t);
      abort_plan.push_back(t + 8);
      run_plan(t + 9 - cyc);
      vectors++;
      if (bus.BUSY !== 1'b0 || bus.ROW_IDX !== ROW_W'(1)) begin
         errors++;
         $display("FAIL abort_next_cycle: busy=%0b row=%0d, want 0 1", bus.BUSY, bus.ROW_IDX);
      end
      run_plan(t + 30 - cyc);
      exp_gen.push_back(t + 2);
      exp_gen.push_back(t + 7);
      exp_rec.push_back(t + 4);
      vectors++;
      if (!q_eq(gen_q, exp_gen) || !q_eq(rec_q, exp_rec) || done_q.size() != 0) begin
         errors++;
         $display("FAIL abort_suppress: gens=%0d recs=%0d dones=%0d, want 2 1 0",
                  gen_q.size(), rec_q.size(), done_q.size());
      end
      vectors++;
      if (bus.FRAME_CNT !== FRAME_W'(exp_frames) || bus.ROW_IDX !== ROW_W'(1)) begin
         errors++;
         $display("FAIL abort_hold: frame=%0d row=%0d, want %0d 1", bus.FRAME_CNT, bus.ROW_IDX, exp_frames);
      end
      clear_all();
      t = cyc + 2;
      fs_plan.push_back(t);
      run_plan(t + 3 - cyc);
      #2;
      RST_N = 1'b0;
      #1;
      vectors++;
      if ({bus.GEN_START, bus.REC_START, bus.ROW_IDX, bus.FRAME_CNT, bus.BUSY, bus.DONE,
           bus.OVERRUN, bus.MISSED_R2S} !== '0) begin
         errors++;
         $display("FAIL async_reset: row=%0d frame=%0d busy=%0b ovr=%0b miss=%0d, want all 0",
                  bus.ROW_IDX, bus.FRAME_CNT, bus.BUSY, bus.OVERRUN, bus.MISSED_R2S);
      end
      tick(3);
      RST_N = 1'b1;
      exp_frames = 0;
      tick(3);
   endtask

   task automatic test_degenerate();
      int t;
      set_cfg(1'b0, 0, 0, 3);
      clear_all();
      t = cyc + 2;
      fs_plan.push_back(t);
      run_plan(t + 1 - cyc);
      // New config mid-frame must not affect the running frame.
      set_cfg(1'b0, 5, 9, 3);
      run_plan(t + 10 - cyc);
      exp_frames++;
      exp_gen.push_back(t + 2);
      exp_rec.push_back(t + 2);
      exp_done.push_back(t + 3);
      vectors++;
      if (!q_eq(gen_q, exp_gen) || !q_eq(rec_q, exp_rec)) begin
         errors++;
         $display("FAIL degen_starts: gen@%0d rec@%0d n=%0d/%0d, want both @2 once",
                  first_or_neg(gen_q) - t, first_or_neg(rec_q) - t, gen_q.size(), rec_q.size());
      end
      vectors++;
      if (!q_eq(done_q, exp_done) || bus.FRAME_CNT !== FRAME_W'(exp_frames) || bus.ROW_IDX !== '0) begin
         errors++;
         $display("FAIL degen_done: done@%0d n=%0d frame=%0d row=%0d, want @3 1 %0d 0",
                  first_or_neg(done_q) - t, done_q.size(), bus.FRAME_CNT, bus.ROW_IDX, exp_frames);
      end
   endtask

   initial begin
      test_reset();
      test_internal();
      test_external();
      test_missed();
      test_overrun();
      test_abort();
      test_degenerate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/frame_row_scheduler.md
Name: frame_row_scheduler

Overview:
Sequences one detector frame of row readouts, driving the start inputs of the DCD data generator (seq_gen) and the switcher/offset recorder (seq_rec). A frame is armed and then started by the frame-sync strobe. Rows are then issued from the row-to-sync strobe or from an internal timer, with a programmable generator-to-recorder delay per row. It also counts missed and overlapping strobes for diagnostics, and runs entirely in the CLK_80 domain between the strobe edge detectors and the sequencer cores.

Parameters:
ROW_W, 8, width of ROWS and ROW_IDX
LEN_W, 16, width of ROW_LEN and REC_DELAY
FRAME_W, 16, width of FRAME_CNT
MISS_W, 8, width of the saturating MISSED_R2S counter

Ports:
CLK  input  1  single clock (CLK_80 domain)
RST_N  input  1  asynchronous, active-low reset
ENABLE  input  1  level; arm/keep arming frames
ABORT  input  1  pulse; immediate return to IDLE
CLR_STATUS  input  1  pulse; clears OVERRUN and MISSED_R2S
EXT_ROW_MODE  input  1  1 = rows triggered by R2S_STROBE; 0 = internal back-to-back rows
ROWS  input  ROW_W  rows per frame (0 treated as 1)
ROW_LEN  input  LEN_W  cycles per row (0 treated as 1)
REC_DELAY  input  LEN_W  cycles from GEN_START to REC_START
FSYNC_STROBE  input  1  single-cycle frame-sync event
R2S_STROBE  input  1  single-cycle row-to-sync event
GEN_START  output  1  single-cycle pulse to seq_gen SEQ_EXT_START
REC_START  output  1  single-cycle pulse to seq_rec SEQ_EXT_START
ROW_IDX  output  ROW_W  index of current or last row
FRAME_CNT  output  FRAME_W  completed frames, wraps
BUSY  output  1  high in ROW_WAIT or ROW_RUN
DONE  output  1  single-cycle pulse at frame end
OVERRUN  output  1  sticky flag: FSYNC_STROBE seen while a frame was running
MISSED_R2S  output  MISS_W  saturating count of ignored R2S_STROBE events

Behaviour:
- Reset (RST_N=0, async): state IDLE. All outputs 0, and all counters and shadow registers 0.
- All outputs are registered.
- States: IDLE, ARMED, ROW_WAIT, ROW_RUN.
- IDLE: ENABLE=1 -> ARMED on the next cycle.
- ARMED, ENABLE=0 -> IDLE.
- ARMED, FSYNC_STROBE=1 -> ROW_WAIT, with these actions:
  - ROWS, ROW_LEN, REC_DELAY and EXT_ROW_MODE latched into shadow registers; they are ignored until the next frame.
  - ROW_IDX <= 0.
- ROW_WAIT, trigger cycle:
  - Trigger cycle is a cycle with R2S_STROBE=1 (EXT_ROW_MODE=1), or the first ROW_WAIT cycle (EXT_ROW_MODE=0).
  - On the next cycle: state ROW_RUN, GEN_START=1, row cycle counter = 0.
- ROW_RUN lasts exactly max(ROW_LEN,1) cycles, counted from index 0, which is the GEN_START cycle.
- REC_START=1 at run cycle index min(REC_DELAY, max(ROW_LEN,1)-1): exactly one per row. REC_DELAY=0 coincides with GEN_START.
- After the last ROW_RUN cycle:
  - Not last row (ROW_IDX != max(ROWS,1)-1): ROW_IDX++, -> ROW_WAIT.
  - Last row: DONE=1 and FRAME_CNT++ (wraps) in the following cycle; state in that cycle is ARMED if ENABLE=1, else IDLE.
- Internal-mode row period: ROW_LEN+1 cycles.
- R2S_STROBE outside ROW_WAIT while BUSY, or in ROW_WAIT with EXT_ROW_MODE=0: MISSED_R2S++, saturating at all-ones. R2S_STROBE in IDLE or ARMED is ignored and not counted.
- FSYNC_STROBE while BUSY: OVERRUN <= 1 (sticky), and the frame continues unaffected.
- ENABLE deassert mid-frame: the frame completes normally, then IDLE.
- ABORT: from any state -> IDLE on the next cycle. GEN_START/REC_START/DONE are suppressed from that cycle on; FRAME_CNT unchanged; ROW_IDX holds.
- ABORT has priority over every other event.
- CLR_STATUS clears OVERRUN and MISSED_R2S. CLR_STATUS coincident with a new overrun/miss event: the event wins (flag=1, count=1).
- DONE coincident with FSYNC_STROBE: the strobe is not accepted (the frame is still busy that cycle) and sets OVERRUN.

Test Plan:
- Internal mode, ROWS=3, ROW_LEN=4, REC_DELAY=2, ENABLE=1, FSYNC at cycle t -> GEN_START at t+2, t+7, t+12; REC_START at t+4, t+9, t+14; DONE at t+16; FRAME_CNT=1; state ARMED.
- External mode, ROWS=2, ROW_LEN=3, REC_DELAY=5, R2S at t+10 and t+20 -> GEN_START at t+11 and t+21; REC_START at t+13 and t+23 (clamped); DONE at t+24.
- External mode, R2S pulses during ROW_RUN ×3 and 300 pulses in the next frame with MISS_W=8 -> MISSED_R2S=3, then 255 (saturated); CLR_STATUS -> 0.
- FSYNC during row 1 of 3 -> OVERRUN=1, frame still issues 3 GEN_STARTs, DONE once; next FSYNC in ARMED starts a new frame.
- ABORT during ROW_RUN of row 1 -> IDLE next cycle, no further GEN_START/REC_START/DONE, FRAME_CNT unchanged; RST_N low mid-frame -> all outputs 0 immediately (async).
- ROWS=0, ROW_LEN=0 -> one row of 1 cycle: GEN_START and REC_START in the same cycle, DONE the next cycle; change ROWS mid-frame -> current frame uses the latched value.
